// File: rtl/keypad_scan_drv.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_drv
// Brief    : Column-scanned 4x4 keypad driver. Drives one active-low column
//            per slot and samples the synchronized active-low rows. It
//            debounces whole scan frames and emits a one-cycle key event
//            carrying a 4-bit hex code.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_drv #(
    parameter int SCAN_DIV        = 50000,  // clock cycles per column slot (>= 4)
    parameter int DEBOUNCE_FRAMES = 4       // identical frames to accept (>= 1)
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int                 c_CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                 c_DB_W      = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_DB_W-1:0]  c_DB_MAX    = c_DB_W'(DEBOUNCE_FRAMES);
    localparam logic [c_DB_W-1:0]  c_DB_ONE    = c_DB_W'(1);
    // Candidate encoding: 0..15 = single key code, plus two special values.
    localparam logic [4:0]         c_CAND_NONE  = 5'd16;
    localparam logic [4:0]         c_CAND_MULTI = 5'd17;

    typedef enum logic [0:0] {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_CNT_W-1:0] r_slot_cnt;
    logic [1:0]         r_col_idx;
    logic [15:0]        r_frame;       // 1 = key seen pressed, bit {row, col}
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [4:0]         r_prev_cand;
    state_t             r_state;
    logic               r_key_valid;
    logic [3:0]         r_key_code;
    logic               r_key_held;

    logic               w_sample;
    logic               w_frame_end;
    logic [15:0]        w_frame_now;
    logic [4:0]         w_nkeys;
    logic [3:0]         w_idx;
    logic [3:0]         w_code;
    logic [4:0]         w_cand;
    logic [c_DB_W-1:0]  w_db_next;
    logic               w_stable;
    state_t             w_state_next;
    logic               w_valid_next;
    logic [3:0]         w_code_next;
    logic               w_held_next;

    assign w_sample    = (r_slot_cnt == c_SLOT_LAST);
    assign w_frame_end = w_sample && (r_col_idx == 2'd3);
    assign col         = ~(4'b0001 << r_col_idx);
    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_held    = r_key_held;

    // Two-flop synchronizer for the asynchronous row inputs (idle = pulled up).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Slot counter and column index; the column steps right after its sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_col_idx  <= 2'd0;
        end else if (w_sample) begin
            r_slot_cnt <= '0;
            r_col_idx  <= r_col_idx + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Frame image including the column being sampled right now.
    always_comb begin
        w_frame_now = r_frame;
        for (int r = 0; r < 4; r++) begin
            w_frame_now[{2'(r), r_col_idx}] = ~r_row_sync[r];
        end
    end

    // Frame accumulator: each sample overwrites the current column's four bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame <= '0;
        end else if (w_sample) begin
            r_frame <= w_frame_now;
        end
    end

    // Count pressed keys and remember the position of the last one found.
    always_comb begin
        w_nkeys = 5'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame_now[i]) begin
                w_nkeys = w_nkeys + 5'd1;
                w_idx   = 4'(i);
            end
        end
    end

    // Keypad legend: position {row, col} to hex code.
    always_comb begin
        w_code = 4'h0;
        case (w_idx)
            4'd0:  w_code = 4'h1;
            4'd1:  w_code = 4'h2;
            4'd2:  w_code = 4'h3;
            4'd3:  w_code = 4'hA;
            4'd4:  w_code = 4'h4;
            4'd5:  w_code = 4'h5;
            4'd6:  w_code = 4'h6;
            4'd7:  w_code = 4'hB;
            4'd8:  w_code = 4'h7;
            4'd9:  w_code = 4'h8;
            4'd10: w_code = 4'h9;
            4'd11: w_code = 4'hC;
            4'd12: w_code = 4'h0;
            4'd13: w_code = 4'hF;
            4'd14: w_code = 4'hE;
            default: w_code = 4'hD;
        endcase
    end

    // Frame candidate and the debounce count it would produce.
    always_comb begin
        if (w_nkeys == 5'd0) begin
            w_cand = c_CAND_NONE;
        end else if (w_nkeys == 5'd1) begin
            w_cand = {1'b0, w_code};
        end else begin
            w_cand = c_CAND_MULTI;
        end
        if (w_cand == r_prev_cand) begin
            w_db_next = (r_db_cnt == c_DB_MAX) ? c_DB_MAX : r_db_cnt + c_DB_ONE;
        end else begin
            w_db_next = c_DB_ONE;
        end
        w_stable = (w_db_next == c_DB_MAX);
    end

    // Debounce history, updated once per frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_db_cnt    <= '0;
            r_prev_cand <= c_CAND_NONE;
        end else if (w_frame_end) begin
            r_db_cnt    <= w_db_next;
            r_prev_cand <= w_cand;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RELEASED;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key_valid <= w_valid_next;
            r_key_code  <= w_code_next;
            r_key_held  <= w_held_next;
        end
    end

    // Press/release decisions at frame end; no rollover while pressed.
    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        w_code_next  = r_key_code;
        w_held_next  = r_key_held;
        if (w_frame_end && w_stable) begin
            case (r_state)
                ST_RELEASED: begin
                    if (!w_cand[4]) begin
                        w_state_next = ST_PRESSED;
                        w_valid_next = 1'b1;
                        w_code_next  = w_cand[3:0];
                        w_held_next  = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (w_cand == c_CAND_NONE) begin
                        w_state_next = ST_RELEASED;
                        w_held_next  = 1'b0;
                    end
                end
                default: w_state_next = ST_RELEASED;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_drv
// Brief    : Self-checking bench for keypad_scan_drv with a frame-level
//            keypad/debounce reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_drv;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_FRAMES = 3;
    localparam int FRAME           = 4 * SCAN_DIV;
    localparam int NONE            = 16;
    localparam int MULTI           = 17;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] keys = '0;   // pressed keys, bit index row*4+col

    int errors = 0;
    int checks = 0;

    // frame observations
    logic [3:0] f_col [FRAME];
    int         f_early;
    int         f_double;
    logic       f_valid;
    logic [3:0] f_code;
    logic       f_held;
    logic       prev_valid = 1'b0;

    // reference model state
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    int         m_prev;
    int         m_cnt;
    bit         m_pressed;
    logic [3:0] m_code;
    logic       m_held;

    keypad_scan_drv #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    // Passive matrix: a row reads low when a pressed key sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    task automatic model_reset();
        m_prev    = NONE;
        m_cnt     = 0;
        m_pressed = 0;
        m_code    = 4'h0;
        m_held    = 1'b0;
    endtask

    // One whole frame with key set k held throughout; returns expected pulse.
    task automatic model_step(input logic [15:0] k, output logic pulse);
        int n;
        int cand;
        n    = $countones(k);
        cand = NONE;
        if (n > 1) cand = MULTI;
        else if (n == 1) begin
            for (int i = 0; i < 16; i++) if (k[i]) cand = int'(kmap[i]);
        end
        m_cnt  = (cand == m_prev) ? ((m_cnt + 1 > DEBOUNCE_FRAMES) ? DEBOUNCE_FRAMES : m_cnt + 1) : 1;
        m_prev = cand;
        pulse  = 1'b0;
        if (m_cnt == DEBOUNCE_FRAMES) begin
            if (!m_pressed && cand < NONE) begin
                m_pressed = 1;
                m_code    = 4'(cand);
                m_held    = 1'b1;
                pulse     = 1'b1;
            end else if (m_pressed && cand == NONE) begin
                m_pressed = 0;
                m_held    = 1'b0;
            end
        end
    endtask

    // Drive one frame of keys and record what the DUT shows.
    task automatic run_frame(input logic [15:0] k);
        keys    = k;
        f_early = 0;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clock);
            #1;
            f_col[i-1] = col;
            if (i < FRAME && key_valid) f_early++;
            if (key_valid && prev_valid) f_double++;
            prev_valid = key_valid;
        end
        f_valid = key_valid;
        f_code  = key_code;
        f_held  = key_held;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", col); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
        model_reset();
        prev_valid = 1'b0;
        f_double   = 0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_scan_order();
        logic exp;
        for (int f = 0; f < 10; f++) begin
            model_step(16'h0000, exp);
            run_frame(16'h0000);
            for (int i = 1; i <= FRAME; i++) begin
                checks++;
                if (f_col[i-1] !== ~(4'b0001 << ((i / SCAN_DIV) % 4))) begin
                    errors++;
                    $display("FAIL scan_col frame %0d cyc %0d got %b want %b", f, i, f_col[i-1], ~(4'b0001 << ((i / SCAN_DIV) % 4)));
                end
            end
            checks++; if ((f_early != 0) || (f_valid !== 1'b0)) begin errors++; $display("FAIL scan_valid frame %0d early=%0d end=%b want none", f, f_early, f_valid); end
            checks++; if (f_held !== 1'b0) begin errors++; $display("FAIL scan_held frame %0d got %b want 0", f, f_held); end
        end
    endtask

    task automatic test_clean_press();
        logic exp;
        int   pulses = 0;
        int   pframe = -1;
        for (int f = 0; f < 5; f++) begin
            model_step(16'h0020, exp);
            run_frame(16'h0020);
            if (f_valid === 1'b1) begin pulses++; pframe = f; end
            checks++; if (f_valid !== exp) begin errors++; $display("FAIL press_valid frame %0d got %b want %b", f, f_valid, exp); end
            checks++; if (f_early != 0) begin errors++; $display("FAIL press_early frame %0d got %0d want 0", f, f_early); end
            checks++; if (f_held !== m_held) begin errors++; $display("FAIL press_held frame %0d got %b want %b", f, f_held, m_held); end
            if (exp) begin checks++; if (f_code !== 4'h5) begin errors++; $display("FAIL press_code got %h want 5", f_code); end end
        end
        checks++; if (pulses != 1 || pframe != 2) begin errors++; $display("FAIL press_timing got %0d pulses at frame %0d want 1 at frame 2", pulses, pframe); end
    endtask

    task automatic test_release();
        logic        exp;
        logic [15:0] seq [12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000,
                                  16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
        int          drop = -1;
        for (int f = 0; f < 12; f++) begin
            model_step(seq[f], exp);
            run_frame(seq[f]);
            if (f < 4 && drop < 0 && f_held === 1'b0) drop = f;
            checks++; if (f_valid !== exp) begin errors++; $display("FAIL release_valid frame %0d got %b want %b", f, f_valid, exp); end
            checks++; if (f_early != 0) begin errors++; $display("FAIL release_early frame %0d got %0d want 0", f, f_early); end
            checks++; if (f_held !== m_held) begin errors++; $display("FAIL release_held frame %0d got %b want %b", f, f_held, m_held); end
            if (exp) begin checks++; if (f_code !== 4'hD) begin errors++; $display("FAIL release_code got %h want d", f_code); end end
        end
        checks++; if (drop != 2) begin errors++; $display("FAIL release_timing held dropped at frame %0d want 2", drop); end
    endtask

    task automatic test_bounce();
        logic        exp;
        logic [15:0] k;
        int          pulses = 0;
        for (int f = 0; f < 16; f++) begin
            k = (f < 8) ? ((f % 2 == 0) ? 16'h0400 : 16'h0000) : ((f < 12) ? 16'h0400 : 16'h0000);
            model_step(k, exp);
            run_frame(k);
            if (f_valid === 1'b1) pulses++;
            checks++; if (f_valid !== exp) begin errors++; $display("FAIL bounce_valid frame %0d got %b want %b", f, f_valid, exp); end
            checks++; if (f_early != 0) begin errors++; $display("FAIL bounce_early frame %0d got %0d want 0", f, f_early); end
            checks++; if (f_held !== m_held) begin errors++; $display("FAIL bounce_held frame %0d got %b want %b", f, f_held, m_held); end
            if (exp) begin checks++; if (f_code !== 4'h9) begin errors++; $display("FAIL bounce_code got %h want 9", f_code); end end
            if (f == 7) begin checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_toggle got %0d pulses want 0", pulses); end end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_total got %0d pulses want 1", pulses); end
    endtask

    task automatic test_multi_key();
        logic        exp;
        logic [15:0] k;
        int          pulses = 0;
        for (int f = 0; f < 12; f++) begin
            k = (f < 4) ? 16'h0003 : ((f < 8) ? 16'h0001 : 16'h0000);
            model_step(k, exp);
            run_frame(k);
            if (f_valid === 1'b1) pulses++;
            checks++; if (f_valid !== exp) begin errors++; $display("FAIL multi_valid frame %0d got %b want %b", f, f_valid, exp); end
            checks++; if (f_held !== m_held) begin errors++; $display("FAIL multi_held frame %0d got %b want %b", f, f_held, m_held); end
            if (exp) begin checks++; if (f_code !== 4'h1) begin errors++; $display("FAIL multi_code got %h want 1", f_code); end end
            if (f == 3) begin checks++; if (pulses != 0) begin errors++; $display("FAIL multi_both got %0d pulses want 0", pulses); end end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL multi_total got %0d pulses want 1", pulses); end
    endtask

    task automatic test_reset_mid_frame();
        logic exp;
        int   pframe = -1;
        for (int f = 0; f < 4; f++) begin
            model_step(16'h0100, exp);
            run_frame(16'h0100);
        end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rst_pre_held got %b want 1", key_held); end
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rst_mid_col got %b want 1110", col); end
        checks++; if (key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'h0) begin
            errors++; $display("FAIL rst_mid_outs got held=%b valid=%b code=%h want 0/0/0", key_held, key_valid, key_code);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset      = 1'b0;
        prev_valid = 1'b0;
        model_reset();
        for (int f = 0; f < 5; f++) begin
            model_step(16'h0100, exp);
            run_frame(16'h0100);
            if (f_valid === 1'b1 && pframe < 0) pframe = f;
            checks++; if (f_valid !== exp) begin errors++; $display("FAIL rst_repulse_valid frame %0d got %b want %b", f, f_valid, exp); end
            checks++; if (f_held !== m_held) begin errors++; $display("FAIL rst_repulse_held frame %0d got %b want %b", f, f_held, m_held); end
            if (exp) begin checks++; if (f_code !== 4'h7) begin errors++; $display("FAIL rst_repulse_code got %h want 7", f_code); end end
        end
        checks++; if (pframe != 2) begin errors++; $display("FAIL rst_repulse_timing pulse at frame %0d want 2", pframe); end
        for (int f = 0; f < 4; f++) begin
            model_step(16'h0000, exp);
            run_frame(16'h0000);
        end
    endtask

    task automatic test_random();
        logic        exp;
        logic [15:0] k;
        int          sel;
        int          hold;
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) k = 16'h0000;
            else if (sel < 8) k = 16'h0001 << $urandom_range(0, 15);
            else k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            if (s == 39) k = 16'h0000;
            hold = (s == 39) ? 4 : $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) begin
                model_step(k, exp);
                run_frame(k);
                checks++; if (f_valid !== exp) begin errors++; $display("FAIL rand_valid seg %0d keys %h got %b want %b", s, k, f_valid, exp); end
                checks++; if (f_early != 0) begin errors++; $display("FAIL rand_early seg %0d got %0d want 0", s, f_early); end
                checks++; if (f_held !== m_held) begin errors++; $display("FAIL rand_held seg %0d got %b want %b", s, f_held, m_held); end
                checks++; if (f_code !== m_code) begin errors++; $display("FAIL rand_code seg %0d got %h want %h", s, f_code, m_code); end
            end
        end
        checks++; if (f_double != 0) begin errors++; $display("FAIL back_to_back_valid got %0d double pulses want 0", f_double); end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_clean_press();
        test_release();
        test_bounce();
        test_multi_key();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
